vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Owns the single pixel-write port (x, y, colour, plot) of the VGA adapter and shares it between two drawing clients.
- Contains a built-in full-screen clear sequencer with highest priority.
- At most one pixel is written per clock. Clients use a req/ack handshake; the clear sweep is started by a single pulse.
- Sits between the drawing FSMs and the VGA adapter in the top level.

Parameters:
WIDTH, 160, screen width in pixels; x range 0..WIDTH-1
HEIGHT, 120, screen height in pixels; y range 0..HEIGHT-1

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
clear_start  input  1  one-cycle pulse: start a full-screen clear
clear_colour  input  3  fill colour, sampled with clear_start
clear_busy  output  1  high while the clear sweep runs
c0_req  input  1  client 0 pixel request; held with c0_x/c0_y/c0_colour until ack
c0_x  input  8  client 0 x
c0_y  input  7  client 0 y
c0_colour  input  3  client 0 colour
c0_ack  output  1  one-cycle pulse: client 0 pixel consumed
c1_req, c1_x, c1_y, c1_colour, c1_ack  same as client 0, widths 1/8/7/3/1
vga_x  output  8  pixel x to adapter
vga_y  output  7  pixel y to adapter
vga_colour  output  3  pixel colour to adapter
vga_plot  output  1  write strobe; vga_x/vga_y/vga_colour valid when high

Behaviour:
- All outputs are registered.
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, c0_ack=0, c1_ack=0, clear_busy=0; state=ARB; last_grant=1, so client 0 wins the first tie.
- State ARB, evaluated at each edge, in priority order:
  (1) If clear_start=1: latch clear_colour, go to CLEAR, plot (0,0) at this same edge, set clear_busy=1, issue no ack.
  (2) Otherwise select among eligible clients. A client is eligible if its req=1 and its ack output is currently 0, so a client acked at edge k cannot be regranted at edge k+1.
  (3) If one client is eligible, grant it. If both are eligible, grant the one not equal to last_grant (round-robin), then update last_grant.
  (4) On a grant: register the client's x/y/colour, assert its ack for exactly one cycle.
     - If x<WIDTH and y<HEIGHT, also assert vga_plot.
     - If out of range, ack with vga_plot=0 (pixel dropped).
  (5) If no client is eligible: vga_plot=0, acks=0.
- State CLEAR:
  - Sweep with x fastest, one pixel per cycle: (0,0),(1,0)..(WIDTH-1,0),(0,1)..(WIDTH-1,HEIGHT-1).
  - Pixel i is plotted at edge k+i, where k is the start edge; colour is the latched clear_colour.
  - After the last pixel (edge k+WIDTH*HEIGHT-1), at the next edge: vga_plot=0, clear_busy=0, state ARB; client arbitration resumes at that same edge.
  - No acks are issued during CLEAR; pending clients stall with req held.
  - clear_start during CLEAR is ignored; the sweep does not restart.
- Clients changing req/coords without an ack is illegal. The arbiter samples only on the granting edge.
- Throughput: one client alone gets 1 pixel per 2 cycles; two alternating clients give 1 pixel per cycle.
- Reset mid-operation: at the reset edge, everything returns to reset values, the clear is aborted and clear_busy=0. Pending requests are not acked until re-arbitrated after reset.
- Counters: x counter 8 bits, y counter 7 bits; no wrap beyond WIDTH-1/HEIGHT-1.

Test Plan:
- Reset, then single request: c0_req=1, (5,7,colour 3) → next edge vga_plot=1, vga_x=5, vga_y=7, vga_colour=3, c0_ack=1 for 1 cycle; if req held with new data, next grant 2 cycles later.
- Contention: c0_req and c1_req held continuously with fixed distinct coords → grants alternate c0,c1,c0,c1 starting with c0; vga_plot high every cycle; no client acked on two consecutive cycles.
- Clear: pulse clear_start with clear_colour=2 → clear_busy high for exactly 19200 cycles; 19200 plots with colour 2 covering each (x,y) exactly once; first (0,0), last (159,119); then clear_busy=0, vga_plot=0.
- Clear vs clients: c1_req held and clear_start pulsed in the same cycle → no c1_ack during the sweep; c1 acked at the edge clear_busy falls. A second clear_start mid-sweep changes nothing.
- Out of range: c0 requests (160,10) and (10,120) → c0_ack pulses, vga_plot stays 0.
- Reset mid-clear: assert reset at pixel 500 → next edge clear_busy=0, vga_plot=0, acks=0; a subsequent c0 request is served normally.

Source files
------------

// File: rtl/vga_plot_arbiter_if.sv
// Pixel-port bundle between the drawing clients, the clear trigger and the VGA adapter.
// The arbiter takes the slave side; whatever drives the clients and the clear takes the master side.
interface vga_plot_arbiter_if;
  logic       clear_start;
  logic [2:0] clear_colour;
  logic       clear_busy;

  logic       c0_req;
  logic [7:0] c0_x;
  logic [6:0] c0_y;
  logic [2:0] c0_colour;
  logic       c0_ack;

  logic       c1_req;
  logic [7:0] c1_x;
  logic [6:0] c1_y;
  logic [2:0] c1_colour;
  logic       c1_ack;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output clear_start, clear_colour,
    output c0_req, c0_x, c0_y, c0_colour,
    output c1_req, c1_x, c1_y, c1_colour,
    input  clear_busy, c0_ack, c1_ack,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  clear_start, clear_colour,
    input  c0_req, c0_x, c0_y, c0_colour,
    input  c1_req, c1_x, c1_y, c1_colour,
    output clear_busy, c0_ack, c1_ack,
    output vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Shares the single VGA pixel-write port between two req/ack drawing clients,
// with a full-screen clear sweep that overrides both clients while it runs.
module vga_plot_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  vga_plot_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  logic [0:0] state;
  logic       last_grant;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       busy_q;
  logic [2:0] clr_colour;
  logic [7:0] cnt_x;
  logic [6:0] cnt_y;
  logic       sweep_done;

  logic       elig0;
  logic       elig1;
  logic       grant0;
  logic       grant1;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;
  logic       sel_in_range;
  logic       last_pixel;

  // A client acked on the previous edge is not eligible, which enforces the
  // two-cycle minimum per client and gives the round-robin its alternation.
  assign elig0 = bus.c0_req & ~ack0_q;
  assign elig1 = bus.c1_req & ~ack1_q;
  assign grant0 = elig0 & (~elig1 | last_grant);
  assign grant1 = elig1 & ~grant0;

  assign sel_x        = grant1 ? bus.c1_x      : bus.c0_x;
  assign sel_y        = grant1 ? bus.c1_y      : bus.c0_y;
  assign sel_colour   = grant1 ? bus.c1_colour : bus.c0_colour;
  assign sel_in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);

  assign last_pixel = (cnt_x == X_LAST) && (cnt_y == Y_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_ARB;
      last_grant <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      clr_colour <= '0;
      cnt_x      <= '0;
      cnt_y      <= '0;
      sweep_done <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      plot_q <= 1'b0;
      if (state == ST_ARB && bus.clear_start) begin
        // Pixel (0,0) goes out on the start edge itself; the counters hold the next pixel.
        state      <= ST_CLEAR;
        busy_q     <= 1'b1;
        clr_colour <= bus.clear_colour;
        x_q        <= '0;
        y_q        <= '0;
        colour_q   <= bus.clear_colour;
        plot_q     <= 1'b1;
        cnt_x      <= 8'd1;
        cnt_y      <= '0;
        sweep_done <= 1'b0;
      end else if (state == ST_CLEAR && !sweep_done) begin
        x_q      <= cnt_x;
        y_q      <= cnt_y;
        colour_q <= clr_colour;
        plot_q   <= 1'b1;
        if (last_pixel) begin
          sweep_done <= 1'b1;
        end else if (cnt_x == X_LAST) begin
          cnt_x <= '0;
          cnt_y <= cnt_y + 7'd1;
        end else begin
          cnt_x <= cnt_x + 8'd1;
        end
      end else begin
        // Leaving the sweep and ordinary arbitration share this path so a
        // stalled client is served on the very edge clear_busy drops.
        if (state == ST_CLEAR) begin
          state      <= ST_ARB;
          busy_q     <= 1'b0;
          sweep_done <= 1'b0;
        end
        if (grant0 || grant1) begin
          x_q        <= sel_x;
          y_q        <= sel_y;
          colour_q   <= sel_colour;
          plot_q     <= sel_in_range;
          ack0_q     <= grant0;
          ack1_q     <= grant1;
          last_grant <= grant1;
        end
      end
    end
  end

  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = plot_q;
  assign bus.c0_ack     = ack0_q;
  assign bus.c1_ack     = ack1_q;
  assign bus.clear_busy = busy_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed handshake, contention and clear
// scenarios plus randomized two-client traffic checked against a per-client scoreboard.
module tb_vga_plot_arbiter;

  localparam int W = 160;
  localparam int H = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } pix_t;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  vga_plot_arbiter_if bus ();

  vga_plot_arbiter #(.WIDTH(W), .HEIGHT(H)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance one rising edge and settle past it before outputs are sampled.
  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_inputs;
    bus.clear_start  = 1'b0;
    bus.clear_colour = 3'd0;
    bus.c0_req = 1'b0; bus.c0_x = '0; bus.c0_y = '0; bus.c0_colour = '0;
    bus.c1_req = 1'b0; bus.c1_x = '0; bus.c1_y = '0; bus.c1_colour = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.c0_ack, bus.c1_ack, bus.clear_busy} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got x=%0d y=%0d col=%0d plot=%b ack0=%b ack1=%b busy=%b, want all zero",
               bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.c0_ack, bus.c1_ack, bus.clear_busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    bus.c0_req = 1'b1; bus.c0_x = 8'd5; bus.c0_y = 7'd7; bus.c0_colour = 3'd3;
    tick();
    checks++;
    if ({bus.c0_ack, bus.c1_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {3'b101, 8'd5, 7'd7, 3'd3}) begin
      errors++;
      $display("[TB] FAIL single_grant: got ack0=%b ack1=%b plot=%b (%0d,%0d,%0d), want ack0=1 plot=1 (5,7,3)",
               bus.c0_ack, bus.c1_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    bus.c0_x = 8'd6; bus.c0_y = 7'd8; bus.c0_colour = 3'd4;
    tick();
    checks++;
    if (bus.c0_ack !== 1'b0 || bus.vga_plot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_gap: got ack0=%b plot=%b, want 0 0", bus.c0_ack, bus.vga_plot);
    end
    tick();
    checks++;
    if ({bus.c0_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {2'b11, 8'd6, 7'd8, 3'd4}) begin
      errors++;
      $display("[TB] FAIL single_regrant: got ack0=%b plot=%b (%0d,%0d,%0d), want 1 1 (6,8,4)",
               bus.c0_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    bus.c0_req = 1'b0;
    tick();
    checks++;
    if (bus.c0_ack !== 1'b0 || bus.vga_plot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_release: got ack0=%b plot=%b, want 0 0", bus.c0_ack, bus.vga_plot);
    end
  endtask

  task automatic test_contention;
    int expect_c;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.c0_req = 1'b1; bus.c0_x = 8'd1;  bus.c0_y = 7'd2;  bus.c0_colour = 3'd3;
    bus.c1_req = 1'b1; bus.c1_x = 8'd40; bus.c1_y = 7'd50; bus.c1_colour = 3'd6;
    expect_c = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      ex = (expect_c == 0) ? 8'd1 : 8'd40;
      ey = (expect_c == 0) ? 7'd2 : 7'd50;
      ec = (expect_c == 0) ? 3'd3 : 3'd6;
      checks++;
      if (bus.c0_ack !== (expect_c == 0) || bus.c1_ack !== (expect_c == 1) || bus.vga_plot !== 1'b1 ||
          bus.vga_x !== ex || bus.vga_y !== ey || bus.vga_colour !== ec) begin
        errors++;
        $display("[TB] FAIL contention_%0d: got ack0=%b ack1=%b plot=%b (%0d,%0d,%0d), want client %0d plot=1 (%0d,%0d,%0d)",
                 j, bus.c0_ack, bus.c1_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour,
                 expect_c, ex, ey, ec);
      end
      expect_c = 1 - expect_c;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_out_of_range;
    bus.c0_req = 1'b1; bus.c0_x = 8'd160; bus.c0_y = 7'd10; bus.c0_colour = 3'd1;
    tick();
    checks++;
    if (bus.c0_ack !== 1'b1 || bus.vga_plot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_x: got ack0=%b plot=%b, want 1 0", bus.c0_ack, bus.vga_plot);
    end
    bus.c0_x = 8'd10; bus.c0_y = 7'd120; bus.c0_colour = 3'd2;
    tick();
    checks++;
    if (bus.c0_ack !== 1'b0 || bus.vga_plot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_gap: got ack0=%b plot=%b, want 0 0", bus.c0_ack, bus.vga_plot);
    end
    tick();
    checks++;
    if (bus.c0_ack !== 1'b1 || bus.vga_plot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_y: got ack0=%b plot=%b, want 1 0", bus.c0_ack, bus.vga_plot);
    end
    bus.c0_req = 1'b0;
    tick();
  endtask

  // Each client owns a queue of pixels; every ack must consume exactly the head of that queue.
  task automatic test_random;
    pix_t q0[$];
    pix_t q1[$];
    pix_t p;
    int cyc;
    logic prev0, prev1, req0_edge, req1_edge, inr;
    for (int i = 0; i < 16; i++) begin
      p.x = 8'($urandom_range(0, 175)); p.y = 7'($urandom_range(0, 127)); p.col = 3'($urandom_range(0, 7));
      q0.push_back(p);
      p.x = 8'($urandom_range(0, 175)); p.y = 7'($urandom_range(0, 127)); p.col = 3'($urandom_range(0, 7));
      q1.push_back(p);
    end
    idle_inputs();
    cyc = 0; prev0 = 1'b0; prev1 = 1'b0;
    while ((q0.size() > 0 || q1.size() > 0) && cyc < 2000) begin
      if (!bus.c0_req && q0.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.c0_req = 1'b1; bus.c0_x = q0[0].x; bus.c0_y = q0[0].y; bus.c0_colour = q0[0].col;
      end
      if (!bus.c1_req && q1.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.c1_req = 1'b1; bus.c1_x = q1[0].x; bus.c1_y = q1[0].y; bus.c1_colour = q1[0].col;
      end
      req0_edge = bus.c0_req;
      req1_edge = bus.c1_req;
      tick();
      cyc++;
      checks++;
      if ((bus.c0_ack && (prev0 || !req0_edge)) || (bus.c1_ack && (prev1 || !req1_edge)) ||
          (bus.c0_ack && bus.c1_ack) || (bus.vga_plot && !bus.c0_ack && !bus.c1_ack)) begin
        errors++;
        $display("[TB] FAIL rand_protocol cyc %0d: got ack0=%b ack1=%b plot=%b prev0=%b prev1=%b req0=%b req1=%b, want single legal ack per plot",
                 cyc, bus.c0_ack, bus.c1_ack, bus.vga_plot, prev0, prev1, req0_edge, req1_edge);
      end
      if (bus.c0_ack && q0.size() > 0) begin
        p = q0.pop_front();
        inr = (int'(p.x) < W) && (int'(p.y) < H);
        checks++;
        if (bus.vga_x !== p.x || bus.vga_y !== p.y || bus.vga_colour !== p.col || bus.vga_plot !== inr) begin
          errors++;
          $display("[TB] FAIL rand_c0_pixel: got (%0d,%0d,%0d) plot=%b, want (%0d,%0d,%0d) plot=%b",
                   bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, p.x, p.y, p.col, inr);
        end
        bus.c0_req = 1'b0;
      end
      if (bus.c1_ack && q1.size() > 0) begin
        p = q1.pop_front();
        inr = (int'(p.x) < W) && (int'(p.y) < H);
        checks++;
        if (bus.vga_x !== p.x || bus.vga_y !== p.y || bus.vga_colour !== p.col || bus.vga_plot !== inr) begin
          errors++;
          $display("[TB] FAIL rand_c1_pixel: got (%0d,%0d,%0d) plot=%b, want (%0d,%0d,%0d) plot=%b",
                   bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, p.x, p.y, p.col, inr);
        end
        bus.c1_req = 1'b0;
      end
      prev0 = bus.c0_ack;
      prev1 = bus.c1_ack;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_drain: got %0d/%0d pixels left after %0d cycles, want 0/0", q0.size(), q1.size(), cyc);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_clear;
    int busy_cycles;
    bus.clear_colour = 3'd2;
    bus.clear_start  = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < W * H; i++) begin
      tick();
      bus.clear_start = 1'b0;
      if (bus.clear_busy === 1'b1) busy_cycles++;
      checks++;
      if (bus.vga_plot !== 1'b1 || bus.vga_x !== 8'(i % W) || bus.vga_y !== 7'(i / W) ||
          bus.vga_colour !== 3'd2 || bus.c0_ack !== 1'b0 || bus.c1_ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clear_pixel_%0d: got plot=%b (%0d,%0d,%0d), want plot=1 (%0d,%0d,2)",
                 i, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, i % W, i / W);
      end
    end
    tick();
    checks++;
    if (busy_cycles != W * H || bus.clear_busy !== 1'b0 || bus.vga_plot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_end: got busy_cycles=%0d busy=%b plot=%b, want %0d 0 0",
               busy_cycles, bus.clear_busy, bus.vga_plot, W * H);
    end
  endtask

  task automatic test_clear_vs_clients;
    bus.c1_req = 1'b1; bus.c1_x = 8'd33; bus.c1_y = 7'd44; bus.c1_colour = 3'd5;
    bus.clear_colour = 3'd6;
    bus.clear_start  = 1'b1;
    for (int i = 0; i < W * H; i++) begin
      if (i == 1000) begin
        bus.clear_start  = 1'b1;
        bus.clear_colour = 3'd1;
      end
      tick();
      bus.clear_start = 1'b0;
      checks++;
      if (bus.c1_ack !== 1'b0 || bus.clear_busy !== 1'b1 || bus.vga_x !== 8'(i % W) ||
          bus.vga_y !== 7'(i / W) || bus.vga_colour !== 3'd6) begin
        errors++;
        $display("[TB] FAIL clear_stall_%0d: got ack1=%b busy=%b (%0d,%0d,%0d), want 0 1 (%0d,%0d,6)",
                 i, bus.c1_ack, bus.clear_busy, bus.vga_x, bus.vga_y, bus.vga_colour, i % W, i / W);
      end
    end
    tick();
    checks++;
    if ({bus.clear_busy, bus.c1_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {3'b011, 8'd33, 7'd44, 3'd5}) begin
      errors++;
      $display("[TB] FAIL clear_handover: got busy=%b ack1=%b plot=%b (%0d,%0d,%0d), want 0 1 1 (33,44,5)",
               bus.clear_busy, bus.c1_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    bus.c1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear;
    bus.clear_colour = 3'd7;
    bus.clear_start  = 1'b1;
    for (int i = 0; i <= 500; i++) begin
      tick();
      bus.clear_start = 1'b0;
    end
    checks++;
    if (bus.vga_x !== 8'd20 || bus.vga_y !== 7'd3 || bus.clear_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midclear_pixel500: got (%0d,%0d) busy=%b, want (20,3) 1", bus.vga_x, bus.vga_y, bus.clear_busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.clear_busy !== 1'b0 || bus.vga_plot !== 1'b0 || bus.c0_ack !== 1'b0 || bus.c1_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midclear_reset: got busy=%b plot=%b ack0=%b ack1=%b, want 0 0 0 0",
               bus.clear_busy, bus.vga_plot, bus.c0_ack, bus.c1_ack);
    end
    reset = 1'b0;
    bus.c0_req = 1'b1; bus.c0_x = 8'd20; bus.c0_y = 7'd30; bus.c0_colour = 3'd6;
    tick();
    checks++;
    if ({bus.clear_busy, bus.c0_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {3'b011, 8'd20, 7'd30, 3'd6}) begin
      errors++;
      $display("[TB] FAIL post_reset_grant: got busy=%b ack0=%b plot=%b (%0d,%0d,%0d), want 0 1 1 (20,30,6)",
               bus.clear_busy, bus.c0_ack, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    bus.c0_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_out_of_range();
    test_random();
    test_clear();
    test_clear_vs_clients();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
